// File: rtl/mouse_ps2_pkg.sv
// mouse_ps2_pkg: shared PS/2 receiver state encoding and frame constants.
package mouse_ps2_pkg;
   typedef enum logic [2:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP, RX_DONE} rx_state_e;
   localparam int ERR_PARITY_BIT = 0;
   localparam int ERR_STOP_BIT   = 1;
   localparam int PS2_DATA_BITS  = 8;
endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-FF synchroniser plus glitch filter on a PS/2 line, emitting a one-cycle falling-edge strobe.
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic line_i,
   output logic fall_o
);
   localparam int CW = $clog2(FILTER_LEN) + 1;
   logic [1:0] sync_q;
   logic level_q, level_d, fall_q, flip;
   logic [CW-1:0] cnt_q, cnt_d;
   always_comb begin
      flip    = (sync_q[1] != level_q) && (cnt_q == CW'(FILTER_LEN - 1));
      cnt_d   = (sync_q[1] == level_q || flip) ? '0 : cnt_q + 1'b1;
      level_d = flip ? sync_q[1] : level_q;
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q  <= 2'b11;
         level_q <= 1'b1;
         fall_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync_q  <= {sync_q[0], line_i};
         level_q <= level_d;
         fall_q  <= level_q & ~level_d;
         cnt_q   <= cnt_d;
      end
   end
   assign fall_o = fall_q;
endmodule

// File: rtl/mouse_receiver.sv
// mouse_receiver: PS/2 device-to-host byte deframer (start, 8 data LSB first, odd parity, stop)
// with watchdog abort and a one-cycle BYTE_READY strobe.
module mouse_receiver
   import mouse_ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       CLK_MOUSE_IN,
   input  logic       DATA_MOUSE_IN,
   input  logic       READ_ENABLE,
   output logic [7:0] BYTE_READ,
   output logic [1:0] BYTE_ERROR_CODE,
   output logic       BYTE_READY
);
   localparam int WD_W = $clog2(TIMEOUT_CYCLES);
   rx_state_e state_q, state_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] sh_q, sh_d, byte_q, byte_d;
   logic [1:0] err_q, err_d, dsync_q;
   logic par_q, par_d, rdy_q, rdy_d;
   logic [WD_W-1:0] wd_q, wd_d;
   logic fall, data, busy, timeout;
   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
      .clk_i (CLK),
      .rst_i (RESET),
      .line_i(CLK_MOUSE_IN),
      .fall_o(fall)
   );
   always_comb begin
      data    = dsync_q[1];
      busy    = state_q inside {RX_DATA, RX_PARITY, RX_STOP};
      timeout = busy && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
      wd_d    = (busy && !fall) ? wd_q + 1'b1 : '0;
      state_d = state_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      par_d   = par_q;
      byte_d  = byte_q;
      err_d   = err_q;
      rdy_d   = 1'b0;
      // Aborts take priority over any edge arriving in the same cycle.
      if (state_q != RX_IDLE && (!READ_ENABLE || timeout || state_q == RX_DONE)) begin
         state_d = RX_IDLE;
      end else if (fall) begin
         case (state_q)
            RX_IDLE: begin
               state_d = (READ_ENABLE && !data) ? RX_DATA : RX_IDLE;
               bit_d   = '0;
            end
            RX_DATA: begin
               sh_d[bit_q] = data;
               bit_d       = bit_q + 1'b1;
               state_d     = (bit_q == 3'(PS2_DATA_BITS - 1)) ? RX_PARITY : RX_DATA;
            end
            RX_PARITY: begin
               par_d   = data;
               state_d = RX_STOP;
            end
            RX_STOP: begin
               byte_d               = sh_q;
               err_d[ERR_PARITY_BIT] = ~^{sh_q, par_q};
               err_d[ERR_STOP_BIT]   = ~data;
               rdy_d                = 1'b1;
               state_d              = RX_DONE;
            end
            default: state_d = RX_IDLE;
         endcase
      end
   end
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= RX_IDLE;
         bit_q   <= '0;
         sh_q    <= '0;
         par_q   <= 1'b0;
         byte_q  <= '0;
         err_q   <= '0;
         rdy_q   <= 1'b0;
         wd_q    <= '0;
         dsync_q <= 2'b11;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         par_q   <= par_d;
         byte_q  <= byte_d;
         err_q   <= err_d;
         rdy_q   <= rdy_d;
         wd_q    <= wd_d;
         dsync_q <= {dsync_q[0], DATA_MOUSE_IN};
      end
   end
   assign BYTE_READ       = byte_q;
   assign BYTE_ERROR_CODE = err_q;
   assign BYTE_READY      = rdy_q;
endmodule

// File: tb/tb_mouse_receiver.sv
// tb_mouse_receiver: drives PS/2 frames into mouse_receiver and checks strobes, bytes and error codes.
module tb_mouse_receiver;
   logic clk = 1'b0, rst = 1'b1, cm = 1'b1, dm = 1'b1, en = 1'b1;
   logic [7:0] byte_read;
   logic [1:0] err_code;
   logic       ready;
   int checks = 0, errors = 0;
   int pulses = 0, hi_cnt = 0;
   logic prev_rdy = 1'b0;
   logic [7:0] cap_b = '0;
   logic [1:0] cap_c = '0;
   logic [7:0] last_b;
   logic [1:0] last_c;

   typedef struct {
      logic [7:0] b;
      logic       par;
      logic       stop;
      logic [7:0] eb;
      logic [1:0] ec;
   } vec_t;
   vec_t tbl[4];

   always #5 clk = ~clk;

   mouse_receiver #(.FILTER_LEN(4), .TIMEOUT_CYCLES(2000)) dut (
      .CLK            (clk),
      .RESET          (rst),
      .CLK_MOUSE_IN   (cm),
      .DATA_MOUSE_IN  (dm),
      .READ_ENABLE    (en),
      .BYTE_READ      (byte_read),
      .BYTE_ERROR_CODE(err_code),
      .BYTE_READY     (ready)
   );

   always @(negedge clk) begin
      if (ready) begin
         hi_cnt++;
         if (!prev_rdy) pulses++;
         cap_b = byte_read;
         cap_c = err_code;
      end
      prev_rdy = ready;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: error bit0 when the count of ones over data+parity is even, bit1 when stop is low.
   function automatic logic [1:0] model_code(input logic [7:0] b, input logic p, input logic s);
      model_code = {s ? 1'b0 : 1'b1, ($countones({b, p}) % 2 == 0) ? 1'b1 : 1'b0};
   endfunction

   task automatic send(input logic [7:0] b, input logic p, input logic s, input int nb,
                       input int drop, input bit gl, input int stretch);
      logic [10:0] f;
      f = {s, p, b, 1'b0};
      for (int i = 0; i < nb; i++) begin
         if (i == drop) en = 1'b0;
         dm = f[i];
         if (gl) begin
            repeat (9) @(negedge clk);
            cm = 1'b0;
            repeat (2) @(negedge clk);
            cm = 1'b1;
            repeat (9) @(negedge clk);
         end else repeat (20) @(negedge clk);
         if (i == 5) repeat (stretch) @(negedge clk);
         cm = 1'b0;
         repeat (20) @(negedge clk);
         cm = 1'b1;
      end
      dm = 1'b1;
      repeat (30) @(negedge clk);
   endtask

   task automatic frame(input string nm, input logic [7:0] b, input logic p, input logic s,
                        input int nb, input int drop, input bit gl, input int stretch, input int post,
                        input int ep, input logic [7:0] eb, input logic [1:0] ec);
      int p0;
      p0 = pulses;
      send(b, p, s, nb, drop, gl, stretch);
      repeat (post) @(negedge clk);
      en = 1'b1;
      chk({nm, " pulses"}, pulses - p0, ep);
      if (ep == 1) begin
         chk({nm, " strobe byte"}, {24'h0, cap_b}, {24'h0, eb});
         chk({nm, " strobe code"}, {30'h0, cap_c}, {30'h0, ec});
      end
      chk({nm, " held byte"}, {24'h0, byte_read}, {24'h0, eb});
      chk({nm, " held code"}, {30'h0, err_code}, {30'h0, ec});
      last_b = eb;
      last_c = ec;
   endtask

   initial begin
      int p0;
      logic [7:0] rb;
      logic rp, rs;
      tbl[0] = '{8'hFA, 1'b1, 1'b1, 8'hFA, 2'b00};
      tbl[1] = '{8'hAA, 1'b0, 1'b1, 8'hAA, 2'b01};
      tbl[2] = '{8'h00, 1'b1, 1'b0, 8'h00, 2'b10};
      tbl[3] = '{8'h00, 1'b0, 1'b0, 8'h00, 2'b11};
      repeat (3) @(negedge clk);
      chk("reset byte", {24'h0, byte_read}, 32'h0);
      chk("reset code", {30'h0, err_code}, 32'h0);
      chk("reset ready", {31'h0, ready}, 32'h0);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      for (int i = 0; i < 4; i++)
         frame($sformatf("table%0d", i), tbl[i].b, tbl[i].par, tbl[i].stop, 11, -1, 1'b0, 0, 0,
               1, tbl[i].eb, tbl[i].ec);
      for (int i = 0; i < 6; i++) begin
         rb = 8'($urandom);
         rp = 1'($urandom_range(0, 1));
         rs = 1'($urandom_range(0, 1));
         frame($sformatf("rand%0d", i), rb, rp, rs, 11, -1, 1'b0, 0, 0, 1, rb, model_code(rb, rp, rs));
      end
      frame("timeout partial", 8'h55, 1'b1, 1'b1, 6, -1, 1'b0, 0, 2100, 0, last_b, last_c);
      frame("after timeout", 8'h08, 1'b0, 1'b1, 11, -1, 1'b0, 0, 0, 1, 8'h08, 2'b00);
      frame("long gap", 8'h81, 1'b1, 1'b1, 11, -1, 1'b0, 1500, 0, 1, 8'h81, 2'b00);
      frame("enable drop", 8'hC3, 1'b1, 1'b1, 11, 4, 1'b0, 0, 0, 0, last_b, last_c);
      frame("resend", 8'hC3, 1'b1, 1'b1, 11, -1, 1'b0, 0, 0, 1, 8'hC3, 2'b00);
      frame("glitch", 8'h5A, 1'b1, 1'b1, 11, -1, 1'b1, 0, 0, 1, 8'h5A, 2'b00);
      p0 = pulses;
      send(8'h3C, 1'b1, 1'b1, 7, -1, 1'b0, 0);
      rst = 1'b1;
      #1;
      chk("async reset byte", {24'h0, byte_read}, 32'h0);
      chk("async reset code", {30'h0, err_code}, 32'h0);
      chk("async reset ready", {31'h0, ready}, 32'h0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("reset mid-frame pulses", pulses - p0, 0);
      frame("after reset", 8'h3C, 1'b1, 1'b1, 11, -1, 1'b0, 0, 0, 1, 8'h3C, 2'b00);
      chk("strobe width", hi_cnt, pulses);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
